// File: rtl/reg_wb_scoreboard.sv
// Pending-write scoreboard for the MIPS register file: decode issues destinations,
// writeback retires them, and rs/rt queries report outstanding writes for hazard stalls.
module reg_wb_scoreboard #(
  parameter int CNT_W = 2,
  parameter int TOT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic             i_issue_en,
  input  logic [4:0]       i_issue_addr,
  output logic             o_issue_ready,
  input  logic             i_wb_en,
  input  logic [4:0]       i_wb_addr,
  output logic             o_wb_err,
  input  logic [4:0]       i_rs_addr,
  input  logic [4:0]       i_rt_addr,
  output logic             o_rs_busy,
  output logic             o_rt_busy,
  output logic             o_stall,
  output logic [TOT_W-1:0] o_pend_total
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [TOT_W-1:0] TOT_ONE  = {{(TOT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_cnt [1:31];
  logic [TOT_W-1:0] r_pend_total;
  logic             r_wb_err;

  logic [CNT_W-1:0] w_issue_cnt;
  logic [CNT_W-1:0] w_wb_cnt;
  logic [CNT_W-1:0] w_rs_cnt;
  logic [CNT_W-1:0] w_rt_cnt;
  logic             w_issue_inc;
  logic             w_wb_valid;
  logic             w_wb_dec;
  logic             w_wb_under;

  // Register 0 has no counter; it always reads as zero pending.
  function automatic logic [CNT_W-1:0] cnt_of(input logic [4:0] addr,
                                              input logic [CNT_W-1:0] cnt [1:31]);
    logic [CNT_W-1:0] val;
    if (addr == 5'd0) begin
      val = CNT_ZERO;
    end else begin
      val = cnt[addr];
    end
    return val;
  endfunction

  // Counter lookups, acceptance decode and query outputs.
  always_comb begin
    w_issue_cnt   = cnt_of(i_issue_addr, r_cnt);
    w_wb_cnt      = cnt_of(i_wb_addr, r_cnt);
    w_rs_cnt      = cnt_of(i_rs_addr, r_cnt);
    w_rt_cnt      = cnt_of(i_rt_addr, r_cnt);
    o_issue_ready = !((i_issue_addr != 5'd0) && (w_issue_cnt == CNT_MAX));
    w_issue_inc   = i_issue_en && o_issue_ready && (i_issue_addr != 5'd0);
    w_wb_valid    = i_wb_en && (i_wb_addr != 5'd0);
    w_wb_dec      = w_wb_valid && (w_wb_cnt != CNT_ZERO);
    w_wb_under    = w_wb_valid && (w_wb_cnt == CNT_ZERO);
    o_rs_busy     = (w_rs_cnt != CNT_ZERO);
    o_rt_busy     = (w_rt_cnt != CNT_ZERO);
    o_stall       = o_rs_busy || o_rt_busy;
  end

  // Counter, total and error state; flush squashes any same-cycle issue/wb.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 1; i < 32; i++) begin
        r_cnt[i] <= CNT_ZERO;
      end
      r_pend_total <= {TOT_W{1'b0}};
      r_wb_err     <= 1'b0;
    end else if (i_flush) begin
      for (int i = 1; i < 32; i++) begin
        r_cnt[i] <= CNT_ZERO;
      end
      r_pend_total <= {TOT_W{1'b0}};
      r_wb_err     <= 1'b0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (w_issue_inc && (i_issue_addr == 5'(i)) && !(w_wb_dec && (i_wb_addr == 5'(i)))) begin
          r_cnt[i] <= r_cnt[i] + CNT_ONE;
        end else if (w_wb_dec && (i_wb_addr == 5'(i)) && !(w_issue_inc && (i_issue_addr == 5'(i)))) begin
          r_cnt[i] <= r_cnt[i] - CNT_ONE;
        end else begin
          r_cnt[i] <= r_cnt[i];
        end
      end
      if (w_issue_inc && !w_wb_dec) begin
        r_pend_total <= r_pend_total + TOT_ONE;
      end else if (w_wb_dec && !w_issue_inc) begin
        r_pend_total <= r_pend_total - TOT_ONE;
      end else begin
        r_pend_total <= r_pend_total;
      end
      r_wb_err <= w_wb_under;
    end
  end

  assign o_wb_err     = r_wb_err;
  assign o_pend_total = r_pend_total;

endmodule

// File: doc/reg_wb_scoreboard.md
Name: reg_wb_scoreboard

Overview:
- Tracks pending register-file writes for the pipelined MIPS core.
- Decode issues the 5-bit destination chosen by the rt/rd destination select. Writeback retires the same address when the value lands in the register file.
- Read side answers whether rs/rt have an outstanding write, so the hazard logic can stall.
- It is the consumer end of the destination-address path: write-back/retire versus issue.

Parameters:
- CNT_W, 2, width of each per-register pending counter; max pending per register = 2^CNT_W-1.
- TOT_W, 8, width of pend_total; must hold 31*(2^CNT_W-1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- flush  input  1  synchronous clear of all pending state (branch/exception squash).
- issue_en  input  1  decode issues an instruction that writes a register.
- issue_addr  input  5  destination register of the issuing instruction.
- issue_ready  output  1  issue can be accepted this cycle.
- wb_en  input  1  writeback retires one pending write.
- wb_addr  input  5  register being written back.
- wb_err  output  1  registered 1-cycle pulse: writeback to a register with zero pending.
- rs_addr  input  5  source register 1 query.
- rt_addr  input  5  source register 2 query.
- rs_busy  output  1  rs has at least one pending write.
- rt_busy  output  1  rt has at least one pending write.
- stall  output  1  rs_busy | rt_busy.
- pend_total  output  TOT_W  registered total count of pending writes, all registers.

Behaviour:
- State consists of 31 counters cnt[1..31], each CNT_W wide. Register 0 has no counter and is always reported not busy.
- Reset (reset==0, asynchronous) forces:
  - all cnt to 0;
  - pend_total to 0;
  - wb_err to 0.
  - Combinational outputs follow from this state: issue_ready=1 for any addr, all busy outputs=0.
- Reset asserted mid-operation discards all pending state immediately, with no wait for clk.
- issue_ready (combinational): 0 only when issue_addr!=0 and cnt[issue_addr]==MAX. It does not depend on issue_en or on a same-cycle wb.
- An issue is accepted when issue_en & issue_ready. It then increments cnt[issue_addr] at the clk edge.
- An issue to addr 0 is accepted with no state change; pend_total does not change.
- A writeback with wb_en and wb_addr!=0:
  - if cnt[wb_addr]>0, it decrements the counter at the edge;
  - if cnt[wb_addr]==0, the count is unchanged and wb_err=1 for the following cycle.
- wb to addr 0 is ignored; no error is raised.
- Same-cycle accepted issue and valid wb to the same nonzero address: net change is 0 and no error, provided the count is >0. If the count is 0, the result is count 1 and wb_err=1 (the issue applies, the wb underflows).
- Same-cycle issue and wb to different addresses: both apply independently.
- pend_total is updated incrementally: +1 per accepted nonzero issue, -1 per valid nonzero decrement, net 0 when both occur. It always equals the sum of cnt.
- flush=1 at an edge:
  - clears all cnt and pend_total;
  - has priority over issue and wb in the same cycle (both discarded);
  - forces wb_err=0.
- Busy outputs are combinational from the registered counts only. A same-cycle issue is not visible until the next cycle; a same-cycle wb still shows busy. The hazard logic relies on the register file's internal write-before-read for the retiring cycle.
- wb_err is a registered signal. It is 0 in every cycle not immediately after an underflow.
- Latency: counter update 1 cycle; query 0 cycles (combinational on the registered state).

Test Plan:
- Reset release, no activity; query rs=5, rt=0 -> rs_busy=0, rt_busy=0, stall=0, pend_total=0, issue_ready=1.
- Issue 8; next cycle query rs=8 -> rs_busy=1, stall=1, pend_total=1. Then wb 8 -> next cycle rs_busy=0, pend_total=0, wb_err stays 0.
- Issue 3 three times (CNT_W=2) -> cnt=3, issue_ready=0 for issue_addr=3. A fourth issue_en is ignored (pend_total stays 3). One wb 3 -> issue_ready=1.
- Same cycle issue 9 + wb 9 with cnt[9]=1 -> cnt stays 1, no wb_err. With cnt[12]=0, same cycle issue 12 + wb 12 -> cnt[12]=1, wb_err=1 for exactly one cycle.
- Issue 0 and wb 0 repeatedly -> rs_busy for rs=0 always 0, pend_total 0, wb_err never set.
- Pending writes on regs 4, 7, 31 (pend_total=3); flush together with issue 5 -> next cycle all busy=0, pend_total=0. Then pull reset low mid-cycle with pending regs -> outputs clear immediately, before the next clk edge.
